// File: rtl/acc_sched_pkg.sv
// acc_sched_pkg: shared register map, descriptor layout and FSM encoding for acc_task_scheduler
package acc_sched_pkg;
    localparam logic [7:0] OFF_CTRL   = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_DESC0  = 8'h08;
    localparam logic [7:0] OFF_DESC1  = 8'h0C;
    localparam logic [7:0] OFF_DONE   = 8'h10;
    localparam logic [7:0] OFF_IRQ    = 8'h14;
    localparam int SRC_W = 13;
    localparam int DST_W = 13;
    localparam int LEN_W = 10;
    localparam int KID_W = 2;
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic [DST_W-1:0] dst;
        logic [LEN_W-1:0] len;
        logic [KID_W-1:0] kid;
    } desc_t;
    typedef enum logic [1:0] {S_IDLE, S_CMD, S_RUN, S_RETIRE} state_t;
    localparam int ST_FULL     = 3;
    localparam int ST_EMPTY    = 4;
    localparam int ST_BUSY     = 5;
    localparam int ST_ERR_DROP = 6;
    localparam int ST_ERR_TO   = 7;
    localparam int IRQ_DONE    = 0;
    localparam int IRQ_ERR     = 1;
    function automatic logic [2:0] kid_onehot(input logic [KID_W-1:0] k);
        return 3'(1) << k;
    endfunction
endpackage

// File: rtl/sched_desc_fifo.sv
// sched_desc_fifo: DEPTH-entry descriptor queue with push/pop/flush and occupancy flags
module sched_desc_fifo
    import acc_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  desc_t                    din,
    output desc_t                    dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    desc_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    // flush wins over any same-cycle push or pop
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign dout    = mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/acc_task_scheduler.sv
// acc_task_scheduler: Wishbone-programmed in-order dispatcher of DMA + kernel tasks.
// Define SCHED_TIMEOUT_EN to add a RUN-state watchdog (TIMEOUT_CYCLES).
module acc_task_scheduler
    import acc_sched_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_8000,
    parameter int DEPTH = 4
`ifdef SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        dma_cmd_valid,
    input  logic        dma_cmd_ready,
    output logic [12:0] dma_cmd_src,
    output logic [12:0] dma_cmd_dst,
    output logic [9:0]  dma_cmd_len,
    input  logic        dma_done,
    output logic [2:0]  ap_start,
    input  logic        ap_idle,
    input  logic [2:0]  ap_done,
    output logic        sched_irq
);
    state_t state, nxt;
    desc_t act, head, new_desc;
    logic [SRC_W-1:0] sh_src;
    logic [DST_W-1:0] sh_dst;
    logic [$clog2(DEPTH):0] cnt;
    logic full, empty;
    logic hit, acc, wr, flush, push, push_ok, pop, hs, both, to_hit, to_fire, drop;
    logic w_stat, w_irq, en, dma_seen, ap_seen, err_drop, err_to;
    logic [7:0] off;
    logic [1:0] irq;
    logic [15:0] done_cnt;
    logic [31:0] rdata;
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_dat_i[31:29], wbs_dat_i[15:13]};
    assign hit      = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    // accept only when no ack is pending so a held strobe never acks twice in a row
    assign acc      = hit & ~wbs_ack_o;
    assign wr       = acc & wbs_we_i;
    assign off      = wbs_adr_i[7:0];
    assign flush    = wr & (off == OFF_CTRL) & wbs_dat_i[1];
    assign push     = wr & (off == OFF_DESC1);
    assign w_stat   = wr & (off == OFF_STATUS);
    assign w_irq    = wr & (off == OFF_IRQ);
    assign new_desc = '{src: sh_src, dst: sh_dst, len: wbs_dat_i[9:0], kid: wbs_dat_i[17:16]};
    assign push_ok  = ~full & (|new_desc.len) & ~(&new_desc.kid);
    assign drop     = push & ~push_ok;
    assign pop      = (state == S_IDLE) & en & ~empty & ap_idle & ~flush;
    assign hs       = (state == S_CMD) & dma_cmd_ready;
    assign both     = (dma_seen | dma_done) & (ap_seen | ap_done[act.kid]);
    assign to_fire  = (state == S_RUN) & ~both & to_hit;
    sched_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (wb_clk_i),
        .rst   (wb_rst_i),
        .push  (push & push_ok),
        .pop   (pop),
        .flush (flush),
        .din   (new_desc),
        .dout  (head),
        .count (cnt),
        .full  (full),
        .empty (empty)
    );
`ifdef SCHED_TIMEOUT_EN
    logic [15:0] tcnt;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || hs) tcnt <= '0;
        else if (state == S_RUN) tcnt <= tcnt + 16'd1;
    end
    assign to_hit = (state == S_RUN) & (tcnt == 16'(TIMEOUT_CYCLES - 1));
`else
    assign to_hit = 1'b0;
`endif
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   nxt = pop ? S_CMD : S_IDLE;
            S_CMD:    nxt = dma_cmd_ready ? S_RUN : S_CMD;
            S_RUN:    nxt = both ? S_RETIRE : (to_hit ? S_IDLE : S_RUN);
            default:  nxt = S_IDLE;
        endcase
    end
    assign dma_cmd_valid = state == S_CMD;
    assign dma_cmd_src   = act.src;
    assign dma_cmd_dst   = act.dst;
    assign dma_cmd_len   = act.len;
    assign ap_start      = hs ? kid_onehot(act.kid) : 3'b000;
    assign sched_irq     = |irq;
    always_comb begin
        rdata = '0;
        case (off)
            OFF_CTRL:   rdata = {31'b0, en};
            OFF_STATUS: rdata = {24'b0, err_to, err_drop, state != S_IDLE, empty, full, 3'(cnt)};
            OFF_DESC0:  rdata = {3'b0, sh_dst, 3'b0, sh_src};
            OFF_DONE:   rdata = {16'b0, done_cnt};
            OFF_IRQ:    rdata = {30'b0, irq};
            default:    rdata = '0;
        endcase
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en        <= 1'b0;
            sh_src    <= '0;
            sh_dst    <= '0;
            act       <= '0;
            dma_seen  <= 1'b0;
            ap_seen   <= 1'b0;
            done_cnt  <= '0;
            err_drop  <= 1'b0;
            err_to    <= 1'b0;
            irq       <= '0;
        end else begin
            wbs_ack_o <= acc;
            wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
            if (wr && off == OFF_CTRL) en <= wbs_dat_i[0];
            if (wr && off == OFF_DESC0) begin
                sh_src <= wbs_dat_i[12:0];
                sh_dst <= wbs_dat_i[28:16];
            end
            if (pop) act <= head;
            // completions are latched independently so either order works
            if (hs) begin
                dma_seen <= 1'b0;
                ap_seen  <= 1'b0;
            end else if (state == S_RUN) begin
                dma_seen <= dma_seen | dma_done;
                ap_seen  <= ap_seen | ap_done[act.kid];
            end
            if (state == S_RETIRE) done_cnt <= done_cnt + 16'd1;
            err_drop      <= drop | (err_drop & ~(w_stat & wbs_dat_i[ST_ERR_DROP]));
            err_to        <= to_fire | (err_to & ~(w_stat & wbs_dat_i[ST_ERR_TO]));
            irq[IRQ_DONE] <= (state == S_RETIRE) | (irq[IRQ_DONE] & ~(w_irq & wbs_dat_i[IRQ_DONE]));
            irq[IRQ_ERR]  <= drop | to_fire | (irq[IRQ_ERR] & ~(w_irq & wbs_dat_i[IRQ_ERR]));
        end
    end
endmodule

// File: tb/tb_acc_task_scheduler.sv
// tb_acc_task_scheduler: directed stimulus with a scoreboard monitor for acc_task_scheduler
module tb_acc_task_scheduler;
    localparam logic [31:0] B = 32'h3000_8000;
    logic clk = 1'b0, rst = 1'b1;
    logic stb = 0, cyc = 0, we = 0;
    logic [3:0] sel = 4'hF;
    logic [31:0] adr = 0, wdat = 0;
    logic ack, dma_cmd_valid, dma_cmd_ready = 0, dma_done = 0, ap_idle = 1, sched_irq;
    logic [31:0] rdat;
    logic [12:0] src, dst;
    logic [9:0] len;
    logic [2:0] ap_start, ap_done = 0;
    int passed = 0, total = 0;
    logic [31:0] rd_exp[$];
    string rd_name[$];
    logic [37:0] cmd_exp[$];
    logic [35:0] prev_f;
    logic prev_wait = 0;
    always #5 clk = ~clk;
    acc_task_scheduler #(
        .BASE_ADDR(B), .DEPTH(4)
`ifdef SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .dma_cmd_valid(dma_cmd_valid), .dma_cmd_ready(dma_cmd_ready), .dma_cmd_src(src),
        .dma_cmd_dst(dst), .dma_cmd_len(len), .dma_done(dma_done), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done), .sched_irq(sched_irq)
    );
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask
    function automatic logic [2:0] onehot(input logic [1:0] k);
        logic [2:0] r;
        r = 3'b000;
        r[k] = 1'b1;
        return r;
    endfunction
    always @(negedge clk) begin
        logic [37:0] e;
        if (ack && !we) begin
            chk("read_expected", rd_exp.size() != 0, 1);
            if (rd_exp.size() != 0) chk(rd_name.pop_front(), rdat, rd_exp.pop_front());
        end
        if (dma_cmd_valid && dma_cmd_ready) begin
            chk("dma_cmd_expected", cmd_exp.size() != 0, 1);
            if (cmd_exp.size() != 0) begin
                e = cmd_exp.pop_front();
                chk("dma_cmd_fields", {src, dst, len}, e[37:2]);
                chk("ap_start_handshake", ap_start, onehot(e[1:0]));
            end
        end else if (ap_start != 3'b000) chk("ap_start_stray", ap_start, 3'b000);
        if (dma_cmd_valid && prev_wait) chk("dma_cmd_stable", {src, dst, len}, prev_f);
        prev_wait = dma_cmd_valid && !dma_cmd_ready && !rst;
        prev_f = {src, dst, len};
    end
    task automatic wb_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
        logic got;
        got = 0;
        @(posedge clk); #1;
        stb = 1; cyc = 1; we = w; adr = a; wdat = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = ack;
        end
        if (!got) chk("wb_ack_timeout", got, 1);
        @(posedge clk); #1;
        stb = 0; cyc = 0; we = 0;
    endtask
    task automatic wb_wr(input logic [7:0] o, input logic [31:0] d);
        wb_xfer(B + 32'(o), 1'b1, d);
    endtask
    task automatic wb_rd(input logic [7:0] o, input string nm, input logic [31:0] exp);
        rd_exp.push_back(exp);
        rd_name.push_back(nm);
        wb_xfer(B + 32'(o), 1'b0, 0);
    endtask
    task automatic push_desc(input logic [12:0] s, input logic [12:0] d, input logic [9:0] l, input logic [1:0] k);
        wb_wr(8'h08, {3'b0, d, 3'b0, s});
        wb_wr(8'h0C, {14'b0, k, 6'b0, l});
    endtask
    task automatic wait_valid();
        logic got;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = dma_cmd_valid;
        end
        chk("cmd_valid_seen", got, 1);
    endtask
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_valid", dma_cmd_valid, 0);
        chk("rst_irq", sched_irq, 0);
        wb_rd(8'h04, "rst_status", 32'h10);
        wb_rd(8'h00, "rst_ctrl", 0);
        wb_rd(8'h10, "rst_done_cnt", 0);
        wb_rd(8'h14, "rst_irq_reg", 0);
        // single task, ready held low, kernel done before DMA done
        push_desc(13'h10, 13'h40, 10'd8, 2'd1);
        wb_rd(8'h04, "status_one_queued", 32'h01);
        cmd_exp.push_back({13'h10, 13'h40, 10'd8, 2'd1});
        wb_wr(8'h00, 1);
        wait_valid();
        repeat (3) @(negedge clk);
        @(posedge clk); #1 dma_cmd_ready = 1;
        @(posedge clk); #1 dma_cmd_ready = 0; ap_done = 3'b001;
        @(posedge clk); #1 ap_done = 3'b010;
        @(posedge clk); #1 ap_done = 3'b000;
        repeat (4) @(posedge clk);
        #1 dma_done = 1;
        @(negedge clk);
        chk("irq_before_retire", sched_irq, 0);
        @(posedge clk); #1 dma_done = 0;
        @(negedge clk);
        chk("irq_in_retire", sched_irq, 0);
        @(negedge clk);
        chk("irq_after_retire", sched_irq, 1);
        wb_rd(8'h10, "done_cnt_1", 1);
        wb_rd(8'h14, "irq_done", 1);
        wb_rd(8'h04, "status_idle", 32'h10);
        wb_wr(8'h14, 1);
        @(negedge clk);
        chk("irq_cleared", sched_irq, 0);
        wb_rd(8'h14, "irq_reg_cleared", 0);
        wb_wr(8'h00, 0);
        // overflow and invalid descriptors
        for (int i = 0; i < 5; i++) push_desc(13'(i), 13'(i + 8), 10'd4, 2'(i % 3));
        wb_rd(8'h04, "status_full_drop", 32'h4C);
        wb_rd(8'h14, "irq_err", 2);
        wb_wr(8'h04, 32'hC0);
        wb_rd(8'h04, "status_drop_cleared", 32'h0C);
        wb_wr(8'h00, 2);
        wb_rd(8'h04, "status_flushed", 32'h10);
        wb_rd(8'h00, "ctrl_flush_selfclear", 0);
        push_desc(13'h1, 13'h2, 10'd0, 2'd0);
        push_desc(13'h1, 13'h2, 10'd5, 2'd3);
        wb_rd(8'h04, "status_invalid_dropped", 32'h50);
        wb_wr(8'h20, 32'hFFFF_FFFF);
        wb_rd(8'h20, "unmapped_reads_zero", 0);
        // flush while task 1 runs
        do_reset();
        push_desc(13'h1, 13'h2, 10'd3, 2'd0);
        push_desc(13'h4, 13'h5, 10'd6, 2'd1);
        push_desc(13'h7, 13'h8, 10'd9, 2'd2);
        dma_cmd_ready = 1;
        cmd_exp.push_back({13'h1, 13'h2, 10'd3, 2'd0});
        wb_wr(8'h00, 1);
        wait_valid();
        wb_wr(8'h00, 3);
        wb_rd(8'h04, "status_flush_busy", 32'h30);
        @(posedge clk); #1 ap_done = 3'b001; dma_done = 1;
        @(posedge clk); #1 ap_done = 3'b000; dma_done = 0;
        repeat (3) @(posedge clk);
        wb_rd(8'h10, "done_cnt_after_flush", 1);
        wb_rd(8'h04, "status_after_flush", 32'h10);
        repeat (10) @(posedge clk);
        wb_wr(8'h00, 0);
        dma_cmd_ready = 0;
        // reset while a command is pending
        do_reset();
        push_desc(13'h11, 13'h22, 10'd4, 2'd2);
        wb_wr(8'h00, 1);
        wait_valid();
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mid_valid", dma_cmd_valid, 0);
        chk("rst_mid_ap_start", ap_start, 0);
        #1 rst = 0;
        wb_rd(8'h04, "rst_mid_status", 32'h10);
        wb_rd(8'h10, "rst_mid_done_cnt", 0);
        wb_rd(8'h00, "rst_mid_ctrl", 0);
`ifdef SCHED_TIMEOUT_EN
        push_desc(13'h3, 13'h4, 10'd2, 2'd0);
        dma_cmd_ready = 1;
        cmd_exp.push_back({13'h3, 13'h4, 10'd2, 2'd0});
        wb_wr(8'h00, 1);
        wait_valid();
        @(posedge clk); #1 ap_done = 3'b001;
        @(posedge clk); #1 ap_done = 3'b000;
        repeat (30) @(posedge clk);
        dma_cmd_ready = 0;
        wb_rd(8'h04, "status_timeout", 32'h90);
        wb_rd(8'h14, "irq_timeout", 2);
        wb_rd(8'h10, "done_cnt_timeout", 0);
`endif
        repeat (5) @(negedge clk);
        chk("read_queue_drained", rd_exp.size(), 0);
        chk("cmd_queue_drained", cmd_exp.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
